// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the memory-stage access controller.
package mem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Read data returned when an access is aborted by the timeout.
    localparam logic [31:0] MEM_ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_timeout_ctr.sv
// REQ-phase watchdog counter: cleared when a request is launched, counts
// while the request is outstanding, flags expiry on the last allowed cycle.
module mem_timeout_ctr #(
    parameter int CYCLES = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;

    logic [CW-1:0] cnt;

    assign expired = enable && (cnt == CW'(CYCLES - 1));

    // Count REQ cycles; saturate once expired so the count never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable && !expired)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage data-access controller. Turns a one-cycle load/store from the
// MEM stage into a req/ack handshake with a variable-latency data memory and
// raises memStall until the access completes.
// Optional build macro MEM_TIMEOUT_EN: abort a request after TIMEOUT_CYCLES
// REQ cycles without memAck, returning MEM_ERR_DATA and setting sticky memErr.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clockIn,
    input  logic              reset,
    input  logic              stall,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [ADDR_W-1:0] addrIn,
    input  logic [DATA_W-1:0] wdataIn,
    output logic [DATA_W-1:0] rdataOut,
    output logic              memStall,
    output logic              memReq,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    input  logic              memAck,
    input  logic [DATA_W-1:0] memRdata,
    output logic              memErr
);

    if (TIMEOUT_CYCLES < 1) begin : g_cfg_chk
        $error("mem_access_ctrl: TIMEOUT_CYCLES must be at least 1");
    end

    state_t state, state_nxt;
    logic   access;
    logic   timeout;

    assign access   = memRead | memWrite;
    assign memStall = (state == IDLE && access) || state == REQ;

`ifdef MEM_TIMEOUT_EN
    mem_timeout_ctr #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clockIn),
        .rst_n   (reset),
        .clear   (state == IDLE && access),
        .enable  (state == REQ),
        .expired (timeout)
    );

    // Sticky error flag: set by an abort, cleared only by reset.
    always_ff @(posedge clockIn or negedge reset) begin
        if (!reset)
            memErr <= 1'b0;
        else if (state == REQ && !memAck && timeout)
            memErr <= 1'b1;
    end
`else
    assign timeout = 1'b0;
    assign memErr  = 1'b0;
`endif

    // State register.
    always_ff @(posedge clockIn or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state: an ack always wins over a same-cycle timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (access) state_nxt = REQ;
            REQ:     if (memAck || timeout) state_nxt = DONE;
            DONE:    if (!stall) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered memory interface and load result. Address/data/we are
    // captured only at launch, so they stay stable for the whole REQ phase;
    // a simultaneous read+write launches as a write.
    always_ff @(posedge clockIn or negedge reset) begin
        if (!reset) begin
            memReq   <= 1'b0;
            memWe    <= 1'b0;
            memAddr  <= '0;
            memWdata <= '0;
            rdataOut <= '0;
        end else begin
            memReq <= (state_nxt == REQ);
            case (state)
                IDLE: if (access) begin
                    memAddr  <= addrIn;
                    memWdata <= wdataIn;
                    memWe    <= memWrite;
                end
                REQ: if (memAck) begin
                    if (!memWe) rdataOut <= memRdata;
                end else if (timeout) begin
                    if (!memWe) rdataOut <= DATA_W'(MEM_ERR_DATA);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: reads, writes, DONE stall, back-to-back,
// async reset mid-request and (with MEM_TIMEOUT_EN) the timeout abort.
module tb_mem_access_ctrl;

    logic        clockIn = 1'b0;
    logic        reset;
    logic        stall;
    logic        memRead;
    logic        memWrite;
    logic [31:0] addrIn;
    logic [31:0] wdataIn;
    logic [31:0] rdataOut;
    logic        memStall;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic        memAck;
    logic [31:0] memRdata;
    logic        memErr;

    int checks   = 0;
    int failures = 0;
    int n;

    mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
        .clockIn  (clockIn),
        .reset    (reset),
        .stall    (stall),
        .memRead  (memRead),
        .memWrite (memWrite),
        .addrIn   (addrIn),
        .wdataIn  (wdataIn),
        .rdataOut (rdataOut),
        .memStall (memStall),
        .memReq   (memReq),
        .memWe    (memWe),
        .memAddr  (memAddr),
        .memWdata (memWdata),
        .memAck   (memAck),
        .memRdata (memRdata),
        .memErr   (memErr)
    );

    always #5 clockIn = ~clockIn;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clockIn);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        reset = 1'b0; stall = 1'b0; memRead = 1'b0; memWrite = 1'b0;
        addrIn = '0; wdataIn = '0; memAck = 1'b0; memRdata = '0;
        repeat (2) tick();
        chk("rst_req",   memReq,   0);
        chk("rst_stall", memStall, 0);
        chk("rst_rdata", rdataOut, 0);
        chk("rst_addr",  memAddr,  0);
        chk("rst_we",    memWe,    0);
        chk("rst_err",   memErr,   0);
        reset = 1'b1;
        tick();

        // Read, ack in the first REQ cycle
        memRead = 1'b1; addrIn = 32'h100; wdataIn = 32'h0;
        #1 chk("rd_stall_idle", memStall, 1);
        tick();
        chk("rd_req",       memReq,   1);
        chk("rd_we",        memWe,    0);
        chk("rd_addr",      memAddr,  32'h100);
        chk("rd_stall_req", memStall, 1);
        memAck = 1'b1; memRdata = 32'h12345678;
        tick();
        memAck = 1'b0; memRdata = '0;
        chk("rd_done_state", dut.state, 2);
        chk("rd_stall_done", memStall,  0);
        chk("rd_req_done",   memReq,    0);
        chk("rd_data",       rdataOut,  32'h12345678);
        memRead = 1'b0;
        tick();
        chk("rd_idle_state", dut.state, 0);

        // Write, ack after 5 REQ cycles; inputs change underneath the request
        memWrite = 1'b1; addrIn = 32'h200; wdataIn = 32'hCAFEF00D;
        tick();
        addrIn = 32'hFFFF; wdataIn = 32'h0;
        for (int i = 0; i < 5; i++) begin
            chk("wr_req",   memReq,   1);
            chk("wr_addr",  memAddr,  32'h200);
            chk("wr_wdata", memWdata, 32'hCAFEF00D);
            chk("wr_we",    memWe,    1);
            if (i == 4) begin memAck = 1'b1; memRdata = 32'hBAD0BAD0; end
            tick();
        end
        memAck = 1'b0;
        chk("wr_done_state", dut.state, 2);
        chk("wr_req_done",   memReq,    0);
        chk("wr_stall_done", memStall,  0);
        chk("wr_rdata_kept", rdataOut,  32'h12345678);
        memWrite = 1'b0;
        tick();

        // Read then external stall held in DONE; stray ack ignored
        memRead = 1'b1; addrIn = 32'h300;
        tick();
        memAck = 1'b1; memRdata = 32'h0BADF00D;
        tick();
        memAck = 1'b0; stall = 1'b1;
        chk("stl_data", rdataOut, 32'h0BADF00D);
        for (int i = 0; i < 3; i++) begin
            memAck = (i == 1); memRdata = 32'hFFFFFFFF;
            tick();
            chk("stl_state", dut.state, 2);
            chk("stl_req",   memReq,    0);
            chk("stl_data",  rdataOut,  32'h0BADF00D);
            chk("stl_stall", memStall,  0);
        end
        memAck = 1'b0; stall = 1'b0;
        tick();
        memRead = 1'b0;
        chk("stl_idle", dut.state, 0);
        tick();
        chk("stl_noreissue", memReq, 0);

        // Back-to-back read then write: second request 2 cycles after DONE
        memRead = 1'b1; addrIn = 32'h500;
        tick();
        memAck = 1'b1; memRdata = 32'h55AA55AA;
        tick();
        memAck = 1'b0;
        chk("bb_rd_data", rdataOut, 32'h55AA55AA);
        memRead = 1'b0; memWrite = 1'b1; addrIn = 32'h600; wdataIn = 32'h600D;
        n = 0;
        do begin tick(); n++; end while (!memReq && n < 10);
        chk("bb_gap",  n,       2);
        chk("bb_we",   memWe,   1);
        chk("bb_addr", memAddr, 32'h600);
        memAck = 1'b1;
        tick();
        memAck = 1'b0; memWrite = 1'b0;
        chk("bb_wr_done",  dut.state, 2);
        chk("bb_rd_kept",  rdataOut,  32'h55AA55AA);
        tick();

`ifdef MEM_TIMEOUT_EN
        // Read never acked: abort after 8 REQ cycles
        memRead = 1'b1; addrIn = 32'h700;
        tick();
        n = 0;
        while (memReq && n < 50) begin n++; tick(); end
        chk("to_cycles", n,         8);
        chk("to_state",  dut.state, 2);
        chk("to_data",   rdataOut,  32'hDEADBEEF);
        chk("to_err",    memErr,    1);
        memRead = 1'b0;
        tick();
        memRead = 1'b1; addrIn = 32'h800;
        tick();
        memAck = 1'b1; memRdata = 32'h11;
        tick();
        memAck = 1'b0;
        chk("to_ok_data",    rdataOut, 32'h11);
        chk("to_err_sticky", memErr,   1);
        memRead = 1'b0;
        tick();
`else
        chk("no_err", memErr, 0);
`endif

        // Async reset in the middle of a request
        memRead = 1'b1; addrIn = 32'h900; wdataIn = 32'h99;
        tick();
        chk("rmid_req_pre", memReq,   1);
        chk("rmid_wd_pre",  memWdata, 32'h99);
        memRead = 1'b0; reset = 1'b0;
        #1;
        chk("rmid_req",   memReq,   0);
        chk("rmid_stall", memStall, 0);
        chk("rmid_addr",  memAddr,  0);
        chk("rmid_wdata", memWdata, 0);
        chk("rmid_we",    memWe,    0);
        chk("rmid_rdata", rdataOut, 0);
        chk("rmid_err",   memErr,   0);
        tick();
        reset = 1'b1; memAck = 1'b1; memRdata = 32'h77;
        tick();
        memAck = 1'b0;
        chk("rmid_no_done", dut.state, 0);
        chk("rmid_rdata2",  rdataOut,  0);
        chk("rmid_req2",    memReq,    0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Memory-stage data-access controller; it is the producer of the memStall signal consumed by the MEM/WB buffer.
- Converts a single-cycle load/store request from the MEM stage into a req/ack transaction on a variable-latency data memory.
- Holds memStall high until the access completes, then presents read data for the MEM/WB buffer to capture.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT_CYCLES, 256, cycles in REQ without memAck before abort (used only with MEM_TIMEOUT_EN).

Ports:
- clockIn  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset (reset==0 resets).
- stall  in  1  pipeline stall from hazard unit; same signal the MEM/WB buffer sees.
- memRead  in  1  MEM-stage load request.
- memWrite  in  1  MEM-stage store request.
- addrIn  in  ADDR_W  access address.
- wdataIn  in  DATA_W  store data.
- rdataOut  out  DATA_W  load data, valid while state==DONE.
- memStall  out  1  access in progress; pipeline must hold.
- memReq  out  1  request to memory.
- memWe  out  1  1=write, 0=read; valid with memReq.
- memAddr  out  ADDR_W  latched address.
- memWdata  out  DATA_W  latched store data.
- memAck  in  1  single-cycle completion pulse from memory.
- memRdata  in  DATA_W  read data, valid with memAck.
- memErr  out  1  sticky timeout flag.

Behaviour:
- State register: IDLE, REQ, DONE.
- Reset values (async, on reset==0): state=IDLE, rdataOut=0, memReq=0, memWe=0, memAddr=0, memWdata=0, memErr=0.
- memStall (combinational from state and inputs) = (state==IDLE && (memRead||memWrite)) || state==REQ. It is 0 in DONE.
- memReq, memWe, memAddr and memWdata are registered. memReq is 1 only in REQ.
- IDLE:
  - If memRead||memWrite: latch addrIn and wdataIn into memAddr and memWdata, set memWe=memWrite, go to REQ.
  - Otherwise remain in IDLE.
  - If memRead and memWrite are both 1, the access is treated as a write.
- REQ:
  - memAddr, memWe and memWdata stay stable until memAck.
  - On memAck: if the access is a read, rdataOut<=memRdata; go to DONE. memReq falls on the same edge.
  - A memAck seen outside REQ is ignored.
- DONE:
  - memStall=0, so the MEM/WB buffer captures rdataOut at this edge unless stall=1.
  - If stall=1, remain in DONE with rdataOut held and no re-issue.
  - If stall=0, go to IDLE.
- Minimum latency: access seen at cycle N; memReq high at N+1; with memAck at N+1, state is DONE at N+2. Result: 2 stall cycles; pipeline advances at the end of N+2.
- Back-to-back accesses: the new instruction is seen in IDLE the cycle after DONE and is issued fresh.
- Writes leave rdataOut unchanged.
- Reset asserted mid-REQ: memReq drops immediately (async) and the transaction is abandoned. The memory must tolerate a dropped request.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - Counter clears on entry to REQ and increments each REQ cycle.
  - When the count reaches TIMEOUT_CYCLES-1 with no memAck: go to DONE, set rdataOut=32'hDEADBEEF for reads, set memErr=1 (sticky until reset).
  - memAck in the timeout cycle wins: normal completion, no error.
- MEM_TIMEOUT_EN undefined: REQ waits indefinitely; memErr is tied to 0; no counter logic is present.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, REQ=2'd1, DONE=2'd2) and the MEM_ERR_DATA constant 32'hDEADBEEF.
- One natural sub-module: mem_timeout_ctr (clear, enable, expired output), instantiated only under MEM_TIMEOUT_EN.

Test Plan:
- Read, ack latency 1: memRead=1, addrIn=0x100, memRdata=0x12345678 with memAck one cycle after memReq -> memStall high 2 cycles; rdataOut=0x12345678 in DONE; memWe=0.
- Write, ack latency 5: memWrite=1, addrIn=0x200, wdataIn=0xCAFEF00D -> memReq held 5 cycles with memAddr and memWdata stable; memWe=1; rdataOut unchanged; memStall low in DONE.
- External stall in DONE: stall=1 for 3 cycles after read completes -> state stays DONE, rdataOut held, memReq stays 0 (no re-issue); returns to IDLE when stall=0.
- Back-to-back read then write -> second memReq rises exactly 2 cycles after the first DONE; no gap errors.
- Reset low during REQ -> memReq=0, memStall=0 and all registers 0 immediately; no DONE follows.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES=8 and no memAck -> DONE after 8 REQ cycles; rdataOut=0xDEADBEEF; memErr=1 and stays 1 until reset.
